// File: rtl/ysyx_23060187_mdu_pkg.sv
// ysyx_23060187_mdu_pkg: shared op indices, state encoding and constants for the M-extension unit
package ysyx_23060187_mdu_pkg;
    localparam int XLEN    = 32;
    localparam int OP_MUL  = 0;
    localparam int OP_MULH = 1;
    localparam int OP_DIV  = 2;
    localparam int OP_DIVU = 3;
    localparam int OP_REM  = 4;
    localparam int OP_REMU = 5;
    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/ysyx_23060187_mdu_signfix.sv
// ysyx_23060187_mdu_signfix: magnitude of a signed operand and conditional negate of a result
module ysyx_23060187_mdu_signfix #(
    parameter int IW = 32,
    parameter int OW = 32
) (
    input  logic [IW-1:0] a,
    input  logic          a_signed,
    output logic [IW-1:0] a_abs,
    input  logic [OW-1:0] y,
    input  logic          y_neg,
    output logic [OW-1:0] y_fix
);
    assign a_abs = (a_signed && a[IW-1]) ? -a : a;
    assign y_fix = y_neg ? -y : y;
endmodule

// File: rtl/ysyx_23060187_mdu.sv
// ysyx_23060187_mdu: radix-2 iterative RV32M multiply/divide; YSYX_23060187_MDU_FAST_MUL_EN enables single-cycle multiply
module ysyx_23060187_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);
    import ysyx_23060187_mdu_pkg::*;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [5:0]        op_q;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   b_q, abs1, abs2, rem_fix, fast_res, fast_mul_res, result_nx;
    logic [2*XLEN-1:0] acc, acc_nx, fix64;
    logic [XLEN:0]     sum, diff;
    logic              signed_op, is_div, one_hot, div0, ovf, fast, mul_fast, div_op;
    assign signed_op = op[OP_MULH] | op[OP_DIV] | op[OP_REM];
    assign is_div    = |op[OP_REMU:OP_DIV];
    assign one_hot   = (op != 6'd0) && ((op & (op - 6'd1)) == 6'd0);
    assign div0      = src2 == '0;
    assign ovf       = (op[OP_DIV] | op[OP_REM]) && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1;
`ifdef YSYX_23060187_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] sa, sb, fprod;
    assign sa           = {{XLEN{op[OP_MULH] & src1[XLEN-1]}}, src1};
    assign sb           = {{XLEN{op[OP_MULH] & src2[XLEN-1]}}, src2};
    assign fprod        = sa * sb;
    assign mul_fast     = op[OP_MUL] | op[OP_MULH];
    assign fast_mul_res = op[OP_MUL] ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
    assign mul_fast     = 1'b0;
    assign fast_mul_res = '0;
`endif
    assign fast     = !one_hot || (is_div && (div0 || ovf)) || mul_fast;
    assign fast_res = !one_hot ? '0 :
                      mul_fast ? fast_mul_res :
                      div0 ? ((op[OP_DIV] | op[OP_DIVU]) ? DIV_ZERO_Q : src1) :
                      (op[OP_DIV] ? src1 : '0);
    // One iteration: multiply adds the multiplicand into the high half and shifts right;
    // divide shifts the remainder/quotient pair left and keeps the subtraction if it did not borrow.
    assign div_op = |op_q[OP_REMU:OP_DIV];
    assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    assign diff   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, b_q};
    always_comb acc_nx = div_op ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                                : {sum, acc[XLEN-1:1]};
    ysyx_23060187_mdu_signfix #(.IW(XLEN), .OW(2*XLEN)) u_fix_a (
        .a(src1), .a_signed(signed_op), .a_abs(abs1),
        .y(div_op ? {{XLEN{1'b0}}, acc_nx[XLEN-1:0]} : acc_nx), .y_neg(neg_a ^ neg_b), .y_fix(fix64)
    );
    ysyx_23060187_mdu_signfix #(.IW(XLEN), .OW(XLEN)) u_fix_b (
        .a(src2), .a_signed(signed_op), .a_abs(abs2),
        .y(acc_nx[2*XLEN-1:XLEN]), .y_neg(neg_a), .y_fix(rem_fix)
    );
    assign result_nx = (op_q[OP_REM] | op_q[OP_REMU]) ? rem_fix :
                       op_q[OP_MULH] ? fix64[2*XLEN-1:XLEN] : fix64[XLEN-1:0];
    // Control FSM with registered handshake outputs; flush and rst both abandon any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            cnt       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q     <= op;
                    rd_out   <= rd_in;
                    neg_a    <= signed_op & src1[XLEN-1];
                    neg_b    <= signed_op & src2[XLEN-1];
                    acc      <= {{XLEN{1'b0}}, abs1};
                    b_q      <= abs2;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    if (fast) begin
                        result    <= fast_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        result    <= result_nx;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_23060187_mdu.md
Name: ysyx_23060187_mdu

Overview:
- Iterative multiply/divide unit for the RV32M instructions: mul, mulh, div, divu, rem, remu.
- Sits directly downstream of the main decode controller and consumes its one-hot M-extension decode outputs plus the two register operands.
- Produces a 32-bit writeback result through a valid/ready handshake.
- Radix-2: one bit per cycle for both multiply (shift-add) and divide (restoring), with a one-cycle fast path for the RISC-V divide corner cases.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  6  one-hot {remu,rem,divu,div,mulh,mul}, bit0=mul
- src1  in  XLEN  rs1 value (multiplicand / dividend)
- src2  in  XLEN  rs2 value (multiplier / divisor)
- rd_in  in  5  destination tag, passed through
- flush  in  1  kill any in-flight operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  final result
- rd_out  out  5  tag of the current result
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high and takes priority over all other inputs.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, rd_out=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Request accepted when in_valid&&!flush. On accept, latch op, rd_in, sign flags, and |src1|, |src2| (absolute value only for signed ops: mulh/div/rem).
  - Fast path: if op is div/divu/rem/remu and src2==0, or op=div/rem with src1=0x80000000 and src2=0xFFFFFFFF, load result directly and go to DONE.
  - Op not one-hot: accept, result=0, go to DONE.
  - Otherwise go to CALC with counter=0.
- CALC:
  - One iteration per cycle. Multiply: 64-bit shift-add accumulator. Divide: restoring shift-subtract producing quotient and remainder.
  - Counter increments each cycle. When counter==XLEN-1, the final sign fix is applied and the registered result is loaded; then go to DONE.
  - Sign fix:
    - quotient negated iff the dividend and divisor signs differ;
    - remainder takes the dividend sign;
    - mulh product negated iff the operand signs differ.
  - Result selection: mul returns product[31:0]; mulh returns product[63:32].
- DONE:
  - out_valid=1; result and rd_out are held stable until out_valid&&out_ready, then go to IDLE.
  - in_ready=0 in CALC and DONE; no overlap between operations.
- Latency:
  - accept at cycle N -> out_valid first high in cycle N+33 (iterative path), or N+1 (fast path).
  - Back-to-back throughput: one operation per 34 cycles with out_ready held high.
- Divide corner results:
  - div/divu by 0: quotient=0xFFFFFFFF.
  - rem/remu by 0: remainder=src1.
  - signed overflow: quotient=0x80000000, remainder=0.
- flush:
  - From any state, the next state is IDLE with out_valid=0. The result is discarded and the counter cleared.
  - A flush in the same cycle as in_valid in IDLE blocks the accept.
- rst mid-CALC or mid-DONE: identical to reset values; the in-flight result is never presented.

Optional Feature:
- YSYX_23060187_MDU_FAST_MUL_EN
  - Defined: mul/mulh skip CALC. The full 64-bit signed/unsigned product is computed with a single combinational multiply at accept, loaded into result, and the unit goes to DONE (latency 1). Division is unchanged.
  - Undefined: multiplication uses the 32-cycle shift-add path.

Decomposition:
- Shared package ysyx_23060187_mdu_pkg holds:
  - op bit-index constants (OP_MUL=0 … OP_REMU=5);
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - XLEN;
  - DIV_ZERO_Q constant (all ones).
- One sub-module, ysyx_23060187_mdu_signfix: combinational abs-value on input and conditional negate on output, instanced twice.

Test Plan:
1. mul src1=7, src2=0xFFFFFFFD -> result=0xFFFFFFEB; out_valid exactly 33 cycles after accept.
2. mulh src1=0x80000000, src2=0x80000000 -> result=0x40000000.
3. div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 0xFFFFFFF9/2 -> 0x7FFFFFFC; remu same operands -> 1.
4. div 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000; rem same operands -> 0; all four with out_valid at N+1.
5. Backpressure: out_ready=0 for 10 cycles in DONE -> result and rd_out stable and in_ready=0; the following out_ready=1 pulse returns the unit to IDLE.
6. Abort cases:
   - flush at CALC cycle 15 -> out_valid never asserted, busy=0 next cycle.
   - rst mid-CALC -> all outputs at reset values.
   - a new request afterwards completes correctly.
